// File: rtl/sub16_pkg.sv
// Shared definitions for the nibble-serial 16-bit subtractor: default geometry,
// FSM state encoding and small helpers used by the top level.
package sub16_pkg;

  localparam int SUB_WIDTH = 16;
  localparam int SUB_DIGIT = 4;
  localparam int SUB_NDIG  = SUB_WIDTH / SUB_DIGIT;

  // A single-digit configuration still needs a 1-bit counter to be legal.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

  localparam int SUB_CNT_W = cnt_width(SUB_NDIG);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sub_state_e;

  // Signed overflow of a - b: operands of opposite sign and the result sign
  // differs from the minuend.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                   input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/sub16_nibble_serial_cla4_slice.sv
// Combinational W-bit carry-lookahead adder slice; also exports group
// generate/propagate so it can be chained into a two-level lookahead later.
module cla4_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         grp_g,
  output logic         grp_p
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         acc;
  logic         prod;
  logic         acc_nocin;

  // Each carry is the flat sum-of-products of generates masked by the
  // propagates above them, so no carry depends on a previous carry.
  always_comb begin
    g         = x & y;
    p         = x ^ y;
    c         = '0;
    c[0]      = cin;
    acc       = 1'b0;
    prod      = 1'b1;
    acc_nocin = 1'b0;
    for (int i = 0; i < W; i++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
      acc_nocin = acc;
      c[i+1]    = acc | (prod & cin);
    end
  end

  assign s     = p ^ c[W-1:0];
  assign cout  = c[W];
  assign grp_g = acc_nocin;
  assign grp_p = &p;

endmodule

// File: rtl/sub16_nibble_serial.sv
// Multi-cycle subtractor: diff = a - b - bin, one DIGIT-wide digit per clock
// through a single lookahead slice fed ~b with carry-in = ~borrow.
module sub16_nibble_serial
  import sub16_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int DIGIT = SUB_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  sub_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] slice_s;
  logic             slice_cout;
  logic             slice_g;
  logic             slice_p;
  logic [WIDTH-1:0] diff_step;
  logic             unused_slice_gp;

  always_comb begin
    a_dig = a_q[int'(cnt_q) * DIGIT +: DIGIT];
    b_dig = b_q[int'(cnt_q) * DIGIT +: DIGIT];
  end

  cla4_slice #(
    .W (DIGIT)
  ) u_slice (
    .x     (a_dig),
    .y     (~b_dig),
    .cin   (~borrow_q),
    .s     (slice_s),
    .cout  (slice_cout),
    .grp_g (slice_g),
    .grp_p (slice_p)
  );

  assign unused_slice_gp = slice_g ^ slice_p;

  // diff with the current digit merged in; on the last digit this is the
  // complete result, which the flags are computed from.
  always_comb begin
    diff_step = diff_q;
    diff_step[int'(cnt_q) * DIGIT +: DIGIT] = slice_s;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        diff_d   = diff_step;
        borrow_d = ~slice_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_DIG) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          bout_d  = ~slice_cout;
          ovf_d   = sub_ovf(a_q[WIDTH-1], b_q[WIDTH-1], diff_step[WIDTH-1]);
          zero_d  = (diff_step == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_sub16_nibble_serial.sv
// Directed bench for sub16_nibble_serial: stimulus pushes hand-computed
// results into exp_q, a negedge monitor pops and compares on every done.
module tb_sub16_nibble_serial;

  localparam int W  = 16;
  localparam int EW = W + 3;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         zero;

  logic [EW-1:0] exp_q[$];
  int checks;
  int errors;

  sub16_nibble_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got diff=%0h with empty queue expected no done", diff);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({diff, bout, ovf, zero} !== e) begin
          errors++;
          $display("FAIL result: got diff=%0h bout=%0b ovf=%0b zero=%0b expected diff=%0h bout=%0b ovf=%0b zero=%0b",
                   diff, bout, ovf, zero, e[EW-1:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // driver tasks
  task automatic push_exp(input logic [W-1:0] ed, input logic eb,
                          input logic eo, input logic ez);
    exp_q.push_back({ed, eb, eo, ez});
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic tbin, input logic [W-1:0] ed,
                        input logic eb, input logic eo, input logic ez);
    @(negedge clk);
    start = 1'b1; a = ta; b = tbv; bin = tbin;
    push_exp(ed, eb, eo, ez);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("busy_phase", {busy, done}, 2'b10);
    end
    @(negedge clk);
    check("done_pulse", {busy, done}, 2'b01);
    repeat (2) @(negedge clk);
    check("hold_diff", diff, ed);
    check("idle_after", {busy, done}, 2'b00);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 20);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got busy=1 expected 0");
    end
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 16'h0000);
    check("rst_flags", {bout, ovf, zero}, 3'b000);
    rst_n = 1'b1;

    run_op(16'h03CD, 16'h0701, 1'b0, 16'hFCCC, 1'b1, 1'b0, 1'b0);
    run_op(16'h0701, 16'h03CD, 1'b0, 16'h0334, 1'b0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op(16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // start held high: next op accepted in each done cycle
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'h0001; bin = 1'b0;
    push_exp(16'hFFFE, 1'b0, 1'b0, 1'b0);
    wait_idle(n);
    check("b2b_period", n, 5);
    a = 16'h7FFF; b = 16'hFFFF; bin = 1'b0;
    push_exp(16'h8000, 1'b1, 1'b1, 1'b0);
    wait_idle(n);
    check("b2b_period", n, 5);
    a = 16'h1000; b = 16'h0FFF; bin = 1'b1;
    push_exp(16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    wait_idle(n);
    check("b2b_last", n, 4);
    @(negedge clk);

    // start pulses and operand changes while busy are ignored
    start = 1'b1; a = 16'hA5A5; b = 16'h5A5A; bin = 1'b0;
    push_exp(16'h4B4B, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'h0000; bin = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'h0000; b = 16'hFFFF; bin = 1'b0;
    @(negedge clk);
    check("ignore_busy", {busy, done}, 2'b10);
    @(negedge clk);
    check("ignore_done", {busy, done}, 2'b01);
    @(negedge clk);
    check("no_stray_accept", {busy, done}, 2'b00);

    // reset in the second RUN cycle aborts the operation
    @(negedge clk);
    start = 1'b1; a = 16'h0001; b = 16'h0002; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_diff", diff, 16'h0000);
    check("abort_flags", {bout, ovf, zero}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_idle", busy, 1'b0);
    run_op(16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
